// File: rtl/vga_sprite_compositor.sv
// Composites N_SPRITE rectangular sprites over a selectable background for VGA output.
// Two-stage pixel pipeline with per-sprite flash timers and a per-frame collision mask against sprite 0.
module vga_sprite_compositor #(
    parameter int N_SPRITE     = 4,
    parameter int CW           = 10,
    parameter int COORD_W      = 10,
    parameter int FLASH_FRAMES = 16,
    parameter int BG_R         = 8,
    parameter int BG_G         = 8,
    parameter int BG_B         = 8,
    parameter int CHECK_SHIFT  = 5,
    localparam int IDW         = (N_SPRITE > 1) ? $clog2(N_SPRITE) : 1
) (
    input  logic                         iVGA_CLK,
    input  logic                         iRST_n,
    input  logic [COORD_W-1:0]           iVGA_X,
    input  logic [COORD_W-1:0]           iVGA_Y,
    input  logic [N_SPRITE*COORD_W-1:0]  iSprite_x,
    input  logic [N_SPRITE*COORD_W-1:0]  iSprite_y,
    input  logic [N_SPRITE*COORD_W-1:0]  iSprite_hw,
    input  logic [N_SPRITE*COORD_W-1:0]  iSprite_hh,
    input  logic [N_SPRITE*3*CW-1:0]     iSprite_rgb,
    input  logic [N_SPRITE-1:0]          iSprite_en,
    input  logic [N_SPRITE-1:0]          iFlash,
    input  logic [1:0]                   iBg_mode,
    output logic [CW-1:0]                oRed,
    output logic [CW-1:0]                oGreen,
    output logic [CW-1:0]                oBlue,
    output logic                         oSprite_hit,
    output logic [IDW-1:0]               oSprite_id,
    output logic [N_SPRITE-1:0]          oCollide
);
    localparam int SW = 3 * CW;
    localparam int GW = (CW < COORD_W) ? CW : COORD_W;
    localparam logic [CW-1:0] BGR = CW'(BG_R);
    localparam logic [CW-1:0] BGG = CW'(BG_G);
    localparam logic [CW-1:0] BGB = CW'(BG_B);

    logic [N_SPRITE-1:0] insideC, s1Inside, overlap, acc, flashOn;
    logic [SW-1:0]       bgC, s1Bg, winRgb, sprRgb;
    logic                winHit, prevZero, atZero, fs;
    logic [IDW-1:0]      winId;
    logic [7:0]          flashCnt [N_SPRITE];
    logic [COORD_W:0]    px, py, sx, sy, shw, shh;
    int unsigned         idx;

    assign atZero = (iVGA_X == '0) && (iVGA_Y == '0);
    assign fs     = atZero && !prevZero;

    // One extra bit of headroom so sprites near the origin clip instead of wrapping.
    always_comb begin
        insideC = '0;
        px  = {1'b0, iVGA_X};
        py  = {1'b0, iVGA_Y};
        sx  = '0;
        sy  = '0;
        shw = '0;
        shh = '0;
        for (int unsigned i = 0; i < N_SPRITE; i++) begin
            sx  = {1'b0, iSprite_x[i*COORD_W +: COORD_W]};
            sy  = {1'b0, iSprite_y[i*COORD_W +: COORD_W]};
            shw = {1'b0, iSprite_hw[i*COORD_W +: COORD_W]};
            shh = {1'b0, iSprite_hh[i*COORD_W +: COORD_W]};
            insideC[i] = iSprite_en[i] & (px + shw >= sx) & (px <= sx + shw)
                                       & (py + shh >= sy) & (py <= sy + shh);
        end
    end

    always_comb begin
        bgC = '0;
        case (iBg_mode)
            2'd0: bgC = {BGR, BGG, BGB};
            2'd1: bgC = (iVGA_X[CHECK_SHIFT] ^ iVGA_Y[CHECK_SHIFT]) ?
                        {BGR >> 1, BGG >> 1, BGB >> 1} : {BGR, BGG, BGB};
            2'd2: bgC[2*CW +: GW] = iVGA_X[COORD_W-1 -: GW];
            default: bgC = '0;
        endcase
    end

    always_comb begin
        overlap = '0;
        flashOn = '0;
        for (int unsigned i = 0; i < N_SPRITE; i++) begin
            if (i != 0) overlap[i] = s1Inside[0] & s1Inside[i];
            flashOn[i] = (flashCnt[i] != '0) && flashCnt[i][0];
        end
    end

    // Scanning from the highest index down lets the lowest index overwrite last and win.
    always_comb begin
        winHit = 1'b0;
        winId  = '0;
        winRgb = s1Bg;
        sprRgb = '0;
        idx    = 0;
        for (int unsigned k = 0; k < N_SPRITE; k++) begin
            idx = N_SPRITE - 1 - k;
            if (s1Inside[idx]) begin
                winHit = 1'b1;
                winId  = IDW'(idx);
                sprRgb = iSprite_rgb[idx*SW +: SW];
                winRgb = flashOn[idx] ? ~sprRgb : sprRgb;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            s1Inside    <= '0;
            s1Bg        <= '0;
            prevZero    <= 1'b0;
            oRed        <= '0;
            oGreen      <= '0;
            oBlue       <= '0;
            oSprite_hit <= 1'b0;
            oSprite_id  <= '0;
            acc         <= '0;
            oCollide    <= '0;
            for (int unsigned i = 0; i < N_SPRITE; i++) flashCnt[i] <= '0;
        end else begin
            s1Inside    <= insideC;
            s1Bg        <= bgC;
            prevZero    <= atZero;
            {oRed, oGreen, oBlue} <= winRgb;
            oSprite_hit <= winHit;
            oSprite_id  <= winId;
            // On frame start the current overlap seeds the new accumulator so no pixel is dropped.
            if (fs) begin
                oCollide <= acc;
                acc      <= overlap;
            end else begin
                acc <= acc | overlap;
            end
            for (int unsigned i = 0; i < N_SPRITE; i++) begin
                if (iFlash[i])
                    flashCnt[i] <= 8'(FLASH_FRAMES);
                else if (fs && flashCnt[i] != '0)
                    flashCnt[i] <= flashCnt[i] - 8'd1;
            end
        end
    end
endmodule
